mem_request_arbiter: RTL and testbench

Round-robin front end that sits directly upstream of one main_memory control port. It serialises read/write requests from NUM_CLIENTS requesters onto that single port using valid/ready handshakes. It returns read data, or a write acknowledge, to the granted client as a one-cycle response pulse. One transaction is in flight at a time.

---
 rtl/mem_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/mem_request_arbiter.sv | 111 +++++++++++
 tb/tb_mem_request_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, widths and helpers for the memory request front end
package mem_pkg;

    localparam int MEM_ADDR_WIDTH = 8;
    localparam int MEM_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESPOND = 2'd2
    } arb_state_t;

    // Low bit position of element idx inside a packed vector of width-bit elements.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after last_grant
module rr_arbiter
    import mem_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_grant
);

    logic [IW-1:0] idx;

    // Scan last_grant+1 .. last_grant+N so the previous winner is checked last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(last_grant) + k) % N);
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_request_arbiter.sv
// rtl/mem_request_arbiter.sv - round-robin serialiser of client requests onto one memory port
module mem_request_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH  = MEM_DATA_WIDTH,
    parameter int NUM_CLIENTS = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_CLIENTS-1:0]            req_valid,
    output logic [NUM_CLIENTS-1:0]            req_ready,
    input  logic [NUM_CLIENTS-1:0]            req_write,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_CLIENTS-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]             resp_rdata,
    output logic [ADDR_WIDTH-1:0]             mem_read_addr,
    output logic [ADDR_WIDTH-1:0]             mem_write_addr,
    output logic [DATA_WIDTH-1:0]             mem_write_data,
    output logic                              mem_write,
    input  logic [DATA_WIDTH-1:0]             mem_read_data
);

    localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    arb_state_t             state;
    arb_state_t             next_state;
    logic [IW-1:0]          last_grant;
    logic [IW-1:0]          grant_idx;
    logic [NUM_CLIENTS-1:0] grant;
    logic                   any_grant;
    logic                   handshake;
    logic                   lat_write;
    logic [ADDR_WIDTH-1:0]  lat_addr;
    logic [DATA_WIDTH-1:0]  lat_wdata;
    logic [DATA_WIDTH-1:0]  rdata_q;

    rr_arbiter #(
        .N  (NUM_CLIENTS),
        .IW (IW)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any_grant  (any_grant)
    );

    always_comb begin
        next_state = state;
        req_ready  = '0;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                // A handshake seen during reset would be silently dropped, so hold ready low.
                if (any_grant && !reset) begin
                    req_ready  = grant;
                    handshake  = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE:   next_state = RESPOND;
            RESPOND: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= IW'(NUM_CLIENTS - 1);
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata_q    <= '0;
        end else begin
            if (handshake) begin
                last_grant <= grant_idx;
                lat_write  <= req_write[grant_idx];
                lat_addr   <= req_addr[slice_lo(int'(grant_idx), ADDR_WIDTH) +: ADDR_WIDTH];
                lat_wdata  <= req_wdata[slice_lo(int'(grant_idx), DATA_WIDTH) +: DATA_WIDTH];
            end
            // Writes echo their own data so the response path is the same for both kinds.
            if (state == ISSUE) begin
                rdata_q <= lat_write ? lat_wdata : mem_read_data;
            end
        end
    end

    always_comb begin
        resp_valid = '0;
        if (state == RESPOND) begin
            resp_valid[last_grant] = 1'b1;
        end
    end

    assign resp_rdata     = rdata_q;
    assign mem_read_addr  = lat_addr;
    assign mem_write_addr = lat_addr;
    assign mem_write_data = lat_wdata;
    assign mem_write      = (state == ISSUE) && lat_write && !reset;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// tb/tb_mem_request_arbiter.sv - self-checking bench for mem_request_arbiter
module tb_mem_request_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst4;
    logic [3:0]  req_valid4, req_ready4, req_write4, resp_valid4;
    logic [31:0] req_addr4, req_wdata4;
    logic [7:0]  resp_rdata4, mem_ra4, mem_wa4, mem_wd4, mem_rd4;
    logic        mem_we4;

    logic        rst2;
    logic [1:0]  req_valid2, req_ready2, req_write2, resp_valid2;
    logic [15:0] req_addr2, req_wdata2;
    logic [7:0]  resp_rdata2, mem_ra2, mem_wa2, mem_wd2, mem_rd2;
    logic        mem_we2;

    mem_request_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_CLIENTS(4)) dut4 (
        .clock(clock), .reset(rst4), .req_valid(req_valid4), .req_ready(req_ready4),
        .req_write(req_write4), .req_addr(req_addr4), .req_wdata(req_wdata4),
        .resp_valid(resp_valid4), .resp_rdata(resp_rdata4), .mem_read_addr(mem_ra4),
        .mem_write_addr(mem_wa4), .mem_write_data(mem_wd4), .mem_write(mem_we4),
        .mem_read_data(mem_rd4)
    );

    mem_request_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_CLIENTS(2)) dut2 (
        .clock(clock), .reset(rst2), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_write(req_write2), .req_addr(req_addr2), .req_wdata(req_wdata2),
        .resp_valid(resp_valid2), .resp_rdata(resp_rdata2), .mem_read_addr(mem_ra2),
        .mem_write_addr(mem_wa2), .mem_write_data(mem_wd2), .mem_write(mem_we2),
        .mem_read_data(mem_rd2)
    );

    function automatic logic [7:0] init_val(input int a);
        return 8'((a * 7 + 3) & 255);
    endfunction

    logic [7:0] mem4 [256];
    logic [7:0] mem2 [256];
    logic       mem_loaded = 1'b0;

    assign mem_rd4 = mem4[mem_ra4];
    assign mem_rd2 = mem2[mem_ra2];

    always @(posedge clock) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) begin
                mem4[i] <= init_val(i);
                mem2[i] <= init_val(i);
            end
            mem_loaded <= 1'b1;
        end else begin
            if (mem_we4) mem4[mem_wa4] <= mem_wd4;
            if (mem_we2) mem2[mem_wa2] <= mem_wd2;
        end
    end

    int         n_cmp = 0;
    int         n_bad = 0;
    int         model_last4;
    logic [7:0] ref_mem [256];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive4(input int c, input bit v, input bit w, input logic [7:0] a, input logic [7:0] d);
        req_valid4[c] = v;
        req_write4[c] = w;
        req_addr4[c*8 +: 8]  = a;
        req_wdata4[c*8 +: 8] = d;
    endtask

    task automatic drive2(input int c, input bit v, input bit w, input logic [7:0] a, input logic [7:0] d);
        req_valid2[c] = v;
        req_write2[c] = w;
        req_addr2[c*8 +: 8]  = a;
        req_wdata2[c*8 +: 8] = d;
    endtask

    function automatic int rr_pick(input bit [3:0] p, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (p[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    // One client alone: handshake at once, access next cycle, response the cycle after.
    task automatic do_single(input int c, input bit w, input logic [7:0] a, input logic [7:0] d,
                             input logic [7:0] exp, input string nm);
        @(negedge clock);
        drive4(c, 1'b1, w, a, d);
        #1;
        check({nm, " ready"}, req_ready4, 32'(1 << c));
        check({nm, " we_idle"}, mem_we4, 0);
        model_last4 = c;
        @(negedge clock);
        drive4(c, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check({nm, " we_issue"}, mem_we4, w);
        check({nm, " addr"}, w ? mem_wa4 : mem_ra4, a);
        if (w) check({nm, " wdata"}, mem_wd4, d);
        check({nm, " rv_issue"}, resp_valid4, 0);
        @(negedge clock);
        #1;
        check({nm, " rv"}, resp_valid4, 32'(1 << c));
        check({nm, " rdata"}, resp_rdata4, exp);
        check({nm, " we_resp"}, mem_we4, 0);
        if (w) ref_mem[a] = d;
    endtask

    typedef struct {
        int         c;
        bit         w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [10];

    bit [3:0]   pend;
    logic       pw [4];
    logic [7:0] pa [4];
    logic [7:0] pd [4];
    int         phase, ig, g;
    logic       iw;
    logic [7:0] iexp;

    initial begin
        tbl[0] = '{1, 1'b1, 8'd11,  8'h05, 8'h05};
        tbl[1] = '{3, 1'b0, 8'd11,  8'h00, 8'h05};
        tbl[2] = '{3, 1'b1, 8'd0,   8'hAA, 8'hAA};
        tbl[3] = '{0, 1'b0, 8'd0,   8'h00, 8'hAA};
        tbl[4] = '{2, 1'b1, 8'd255, 8'hC3, 8'hC3};
        tbl[5] = '{1, 1'b0, 8'd255, 8'h00, 8'hC3};
        tbl[6] = '{0, 1'b0, 8'd15,  8'h00, 8'h6C};
        tbl[7] = '{2, 1'b0, 8'd10,  8'h00, 8'h55};
        tbl[8] = '{1, 1'b1, 8'd10,  8'h3E, 8'h3E};
        tbl[9] = '{0, 1'b0, 8'd10,  8'h00, 8'h3E};

        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        rst4 = 1'b1; req_valid4 = '0; req_write4 = '0; req_addr4 = '0; req_wdata4 = '0;
        rst2 = 1'b1; req_valid2 = '0; req_write2 = '0; req_addr2 = '0; req_wdata2 = '0;
        model_last4 = 3;

        // Reset state, then two simultaneous requesters after reset.
        repeat (3) @(negedge clock);
        #1;
        check("rst ready", req_ready4, 0);
        check("rst rv", resp_valid4, 0);
        check("rst rdata", resp_rdata4, 0);
        check("rst we", mem_we4, 0);
        check("rst raddr", mem_ra4, 0);
        check("rst wdata", mem_wd4, 0);
        @(negedge clock);
        rst4 = 1'b0;
        drive4(0, 1'b1, 1'b1, 8'd10, 8'h55);
        drive4(2, 1'b1, 1'b0, 8'd10, 8'h00);
        #1;
        check("t1 first", req_ready4, 4'b0001);
        @(negedge clock);
        drive4(0, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("t1 ready_issue", req_ready4, 0);
        check("t1 we", mem_we4, 1);
        @(negedge clock);
        #1;
        check("t1 rv0", resp_valid4, 4'b0001);
        check("t1 rdata0", resp_rdata4, 8'h55);
        check("t1 ready_resp", req_ready4, 0);
        @(negedge clock);
        #1;
        check("t1 second", req_ready4, 4'b0100);
        @(negedge clock);
        drive4(2, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        @(negedge clock);
        #1;
        check("t1 rv2", resp_valid4, 4'b0100);
        check("t1 rdata2", resp_rdata4, 8'h55);
        ref_mem[10] = 8'h55;
        model_last4 = 2;

        for (int i = 0; i < 10; i++) begin
            do_single(tbl[i].c, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // All clients reading continuously: rotating grants, one every 3 cycles.
        @(negedge clock);
        for (int c = 0; c < 4; c++) drive4(c, 1'b1, 1'b0, 8'(20 + c), 8'h00);
        for (int k = 0; k < 24; k++) begin
            if (k > 0) @(negedge clock);
            #1;
            check("t2 onehot", 32'($countones(req_ready4) <= 1), 1);
            if (k % 3 == 0) begin
                g = (model_last4 + 1) % 4;
                check($sformatf("t2 grant%0d", k / 3), req_ready4, 32'(1 << g));
                model_last4 = g;
            end else begin
                check("t2 ready_busy", req_ready4, 0);
            end
            if (k % 3 == 2) begin
                check("t2 rv", resp_valid4, 32'(1 << g));
                check("t2 rdata", resp_rdata4, ref_mem[20 + g]);
            end else begin
                check("t2 rv_quiet", resp_valid4, 0);
            end
        end
        @(negedge clock);
        for (int c = 0; c < 4; c++) drive4(c, 1'b0, 1'b0, 8'h00, 8'h00);

        // Reset during ISSUE of a write drops it without committing.
        @(negedge clock);
        drive4(1, 1'b1, 1'b1, 8'd15, 8'hFF);
        #1;
        check("t4 ready", req_ready4, 4'b0010);
        @(posedge clock);
        #1;
        rst4 = 1'b1;
        drive4(1, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("t4 we_reset", mem_we4, 0);
        @(posedge clock);
        #1;
        rst4 = 1'b0;
        @(negedge clock);
        #1;
        check("t4 rv_dropped", resp_valid4, 0);
        check("t4 we_after", mem_we4, 0);
        check("t4 rdata_reset", resp_rdata4, 0);
        model_last4 = 3;
        do_single(3, 1'b0, 8'd15, 8'h00, ref_mem[15], "t4 read15");

        // A request raised while busy waits for the next IDLE cycle.
        @(negedge clock);
        drive4(0, 1'b1, 1'b0, 8'd30, 8'h00);
        #1;
        check("t5 first", req_ready4, 4'b0001);
        @(negedge clock);
        drive4(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive4(2, 1'b1, 1'b1, 8'd31, 8'h77);
        #1;
        check("t5 ready_issue", req_ready4, 0);
        @(negedge clock);
        #1;
        check("t5 ready_resp", req_ready4, 0);
        check("t5 rv0", resp_valid4, 4'b0001);
        check("t5 rdata0", resp_rdata4, ref_mem[30]);
        @(negedge clock);
        #1;
        check("t5 accepted", req_ready4, 4'b0100);
        @(negedge clock);
        drive4(2, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("t5 we", mem_we4, 1);
        @(negedge clock);
        #1;
        check("t5 rv2", resp_valid4, 4'b0100);
        check("t5 rdata2", resp_rdata4, 8'h77);
        ref_mem[31] = 8'h77;
        model_last4 = 2;

        // Random traffic against a transaction-level model with a shadow memory.
        pend = '0;
        phase = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clock);
            for (int c = 0; c < 4; c++) begin
                if (!pend[c] && $urandom_range(0, 2) == 0) begin
                    pend[c] = 1'b1;
                    pw[c]   = 1'($urandom_range(0, 1));
                    pa[c]   = 8'($urandom_range(0, 15));
                    pd[c]   = 8'($urandom);
                end
            end
            for (int c = 0; c < 4; c++) drive4(c, pend[c], pw[c], pa[c], pd[c]);
            #1;
            check("rnd onehot", 32'($countones(req_ready4) <= 1), 1);
            if (phase == 2) begin
                check("rnd rv", resp_valid4, 32'(1 << ig));
                check("rnd rdata", resp_rdata4, iexp);
            end else begin
                check("rnd rv_quiet", resp_valid4, 0);
            end
            check("rnd we", mem_we4, (phase == 1) ? iw : 1'b0);
            if (phase == 0 && pend != 4'b0000) begin
                g = rr_pick(pend, model_last4);
                check("rnd grant", req_ready4, 32'(1 << g));
                ig   = g;
                iw   = pw[g];
                iexp = pw[g] ? pd[g] : ref_mem[pa[g]];
                if (pw[g]) ref_mem[pa[g]] = pd[g];
                model_last4 = g;
                pend[g] = 1'b0;
                phase = 1;
            end else begin
                check("rnd ready_idle", req_ready4, 0);
                phase = (phase == 1) ? 2 : 0;
            end
        end

        // Two-client build: lone client 1, then wrap-around to client 0.
        @(negedge clock);
        rst2 = 1'b0;
        drive2(1, 1'b1, 1'b0, 8'd40, 8'h00);
        #1;
        check("t6 lone1", req_ready2, 2'b10);
        @(negedge clock);
        drive2(1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clock);
        #1;
        check("t6 rv1", resp_valid2, 2'b10);
        check("t6 rdata1", resp_rdata2, init_val(40));
        @(negedge clock);
        drive2(0, 1'b1, 1'b1, 8'd41, 8'h9A);
        drive2(1, 1'b1, 1'b0, 8'd41, 8'h00);
        #1;
        check("t6 wrap0", req_ready2, 2'b01);
        @(negedge clock);
        drive2(0, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("t6 we", mem_we2, 1);
        @(negedge clock);
        #1;
        check("t6 rv0", resp_valid2, 2'b01);
        check("t6 rdata0", resp_rdata2, 8'h9A);
        @(negedge clock);
        #1;
        check("t6 then1", req_ready2, 2'b10);
        @(negedge clock);
        drive2(1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clock);
        #1;
        check("t6 rv1b", resp_valid2, 2'b10);
        check("t6 raw", resp_rdata2, 8'h9A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
